// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters, mispredict detection and perf counters
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W = 2,
  parameter int PERF_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       lk_pc,
  input  logic              lk_en,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  input  logic              inv,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_hits,
  output logic [PERF_W-1:0] perf_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag [ENTRIES];
  logic [29:0]        target [ENTRIES];
  logic [CTR_W-1:0]   ctr [ENTRIES];
  logic [IDX_W-1:0]   lk_idx;
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   upd_tag;
  logic               lk_hit;
  logic               upd_hit;
  logic [CTR_W-1:0]   ctr_inc;
  logic [CTR_W-1:0]   ctr_dec;
  logic               unused_pc_lsbs;
  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};
  always_comb begin
    lk_hit = valid[lk_idx] && tag[lk_idx] == lk_tag;
    pred_taken = lk_hit && ctr[lk_idx][CTR_W-1];
    pred_target = pred_taken ? {target[lk_idx], 2'b00} : lk_pc + 32'd4;
    upd_hit = valid[upd_idx] && tag[upd_idx] == upd_tag;
    ctr_inc = ctr[upd_idx] == CTR_MAX ? CTR_MAX : ctr[upd_idx] + 1'b1;
    ctr_dec = ctr[upd_idx] == '0 ? '0 : ctr[upd_idx] - 1'b1;
    mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target));
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end
  // Jumps and taken branches (re)write the whole entry; a not-taken hit only weakens the counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        target[i] <= '0;
        ctr[i] <= '0;
      end
    end else if (inv) begin
      valid <= '0;
    end else if (upd_valid && (upd_is_jump || upd_taken)) begin
      valid[upd_idx] <= 1'b1;
      tag[upd_idx] <= upd_tag;
      target[upd_idx] <= upd_target[31:2];
      ctr[upd_idx] <= upd_is_jump ? CTR_MAX : upd_hit ? ctr_inc : CTR_WEAK;
    end else if (upd_valid && upd_hit) begin
      ctr[upd_idx] <= ctr_dec;
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_lookups <= '0;
      perf_hits <= '0;
      perf_mispred <= '0;
    end else begin
      perf_lookups <= perf_lookups + PERF_W'(lk_en && perf_lookups != PERF_MAX);
      perf_hits <= perf_hits + PERF_W'(lk_en && lk_hit && perf_hits != PERF_MAX);
      perf_mispred <= perf_mispred + PERF_W'(mispredict && perf_mispred != PERF_MAX);
    end
  end
endmodule
